// File: rtl/controlador_varredura.sv
// Scan and scroll controller for a 5x7 LED matrix: column multiplexing with an
// anti-ghosting blank at the start of every slot, and static/scroll/blink modes on a 5x16 frame.
module controlador_varredura #(
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int SCROLL_FRAMES = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch1,
  input  logic        ch0,
  input  logic [79:0] quadro,
  output logic [6:0]  acender_coluna,
  output logic [4:0]  linhas,
  output logic        inicio_quadro,
  output logic [3:0]  deslocamento
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = $clog2(SCROLL_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_CNT0 = CNT_W'(BLANK_CYCLES);
  localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(SCROLL_FRAMES - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_LEFT   = 2'b01,
    M_RIGHT  = 2'b10,
    M_BLINK  = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       col_q, col_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       mode_q, mode_d;
  logic             vis_q, vis_d;
  logic [3:0]       desl_q, desl_d;
  logic [6:0]       acender_q, acender_d;
  logic [4:0]       linhas_q, linhas_d;
  logic             inicio_q, inicio_d;

  logic             start_w;
  logic             step_w;
  logic [3:0]       idx_w;
  logic [4:0]       pix_w;
  logic [6:0]       col_sel_w;

  // Counters describe the slot position; the output registers present it one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      col_q     <= '0;
      fc_q      <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      mode_q    <= M_STATIC;
      vis_q     <= 1'b1;
      desl_q    <= '0;
      acender_q <= 7'h7F;
      linhas_q  <= '0;
      inicio_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      fc_q      <= fc_d;
      sync1_q   <= {ch1, ch0};
      sync2_q   <= sync1_q;
      mode_q    <= mode_d;
      vis_q     <= vis_d;
      desl_q    <= desl_d;
      acender_q <= acender_d;
      linhas_q  <= linhas_d;
      inicio_q  <= inicio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      BLANK: if (cnt_q == BLANK_LAST) state_d = DRIVE;
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = BLANK;
          col_d   = (col_q == 3'd6) ? 3'd0 : col_q + 3'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Frame start: mode latch, frame count and scroll/blink step all happen together.
  always_comb begin
    start_w = (state_q == BLANK) && (cnt_q == '0) && (col_q == 3'd0);
    step_w  = start_w && (fc_q == FC_LAST);
    mode_d  = start_w ? sync2_q : mode_q;
    fc_d    = fc_q;
    desl_d  = desl_q;
    vis_d   = vis_q;

    if (start_w) begin
      fc_d = step_w ? '0 : fc_q + 1'b1;
      if (mode_d != M_BLINK) begin
        vis_d = 1'b1;
      end else if (step_w) begin
        vis_d = ~vis_q;
      end
      if (step_w && mode_d == M_LEFT)  desl_d = desl_q + 4'd1;
      if (step_w && mode_d == M_RIGHT) desl_d = desl_q - 4'd1;
    end
  end

  always_comb begin
    idx_w     = desl_q + {1'b0, col_q};
    col_sel_w = ~(7'b1000000 >> col_q);
    pix_w     = '0;
    for (int r = 0; r < 5; r++) begin
      pix_w[r] = quadro[r*16 + int'(idx_w)];
    end

    inicio_d  = start_w;
    acender_d = 7'h7F;
    linhas_d  = '0;
    if (state_q == DRIVE) begin
      acender_d = vis_q ? col_sel_w : 7'h7F;
      linhas_d  = (cnt_q == DRIVE_CNT0) ? pix_w : linhas_q;
    end
  end

  assign acender_coluna = acender_q;
  assign linhas         = linhas_q;
  assign inicio_quadro  = inicio_q;
  assign deslocamento   = desl_q;

endmodule

// File: tb/tb_controlador_varredura.sv
// Bench for controlador_varredura: a frame-position reference model feeds a scoreboard queue,
// a table of mode phases, and hand-written reset, mode-change and blink sequences.
module tb_controlador_varredura;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int SF    = 2;
  localparam int FRAME = 7 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch1 = 1'b0;
  logic        ch0 = 1'b0;
  logic [79:0] quadro = '0;
  logic [6:0]  acender_coluna;
  logic [4:0]  linhas;
  logic        inicio_quadro;
  logic [3:0]  deslocamento;

  controlador_varredura #(
    .SCAN_DIV(SD), .BLANK_CYCLES(BC), .SCROLL_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch1(ch1), .ch0(ch0), .quadro(quadro),
    .acender_coluna(acender_coluna), .linhas(linhas),
    .inicio_quadro(inicio_quadro), .deslocamento(deslocamento)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] col;
    logic [4:0] lin;
    logic       ini;
    logic [3:0] desl;
  } obs_t;

  typedef struct {
    logic [1:0]  ch;
    int          frames;
    logic [79:0] quadro;
    logic [3:0]  exp_desl;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  int         m_p, m_fc;
  logic [3:0] m_d;
  logic       m_vis;
  logic [1:0] m_mode, m_s1, m_s2;
  logic [4:0] m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_fc = 0; m_d = '0; m_vis = 1'b1;
    m_mode = 2'b00; m_s1 = 2'b00; m_s2 = 2'b00; m_hold = '0;
    exp_q.delete();
  endtask

  // Expected outputs after this edge, derived from the position within the 56-cycle frame.
  task automatic model_step();
    obs_t       e;
    int         col, c;
    logic [6:0] one;
    col = m_p / SD;
    c   = m_p % SD;
    e.ini = (m_p == 0);
    if (m_p == 0) begin
      m_mode = m_s2;
      m_fc++;
      if (m_fc == SF) begin
        m_fc = 0;
        case (m_mode)
          2'b01: m_d = m_d + 4'd1;
          2'b10: m_d = m_d - 4'd1;
          2'b11: m_vis = ~m_vis;
          default: ;
        endcase
      end
      if (m_mode != 2'b11) m_vis = 1'b1;
    end
    if (c < BC) begin
      e.col = 7'h7F;
      e.lin = '0;
    end else begin
      if (c == BC) begin
        for (int r = 0; r < 5; r++) m_hold[r] = quadro[r*16 + ((int'(m_d) + col) % 16)];
      end
      one   = 7'h40 >> col;
      e.col = m_vis ? ~one : 7'h7F;
      e.lin = m_hold;
    end
    e.desl = m_d;
    exp_q.push_back(e);
    m_s2 = m_s1;
    m_s1 = {ch1, ch0};
    m_p  = (m_p + 1) % FRAME;
  endtask

  task automatic sb_pop();
    obs_t e;
    e = exp_q.pop_front();
    check("scan", {15'd0, acender_coluna, linhas, inicio_quadro, deslocamento}, {15'd0, e});
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) sb_pop();
  end

  task automatic wait_frame_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!inicio_quadro && n < 3 * FRAME);
    check("frame_start_seen", {31'd0, inicio_quadro}, 32'd1);
  endtask

  vec_t tbl[8];
  int   n;
  logic [3:0] d0;
  logic found;

  initial begin
    tbl[0] = '{2'b00, 10, 80'h1, 4'd0};
    tbl[1] = '{2'b01,  6, 80'h1, 4'd3};
    tbl[2] = '{2'b01, 26, 80'h0000_8421_F00F_1234_0001, 4'd0};
    tbl[3] = '{2'b10,  2, 80'hAAAA_5555_0F0F_F0F0_8001, 4'd15};
    tbl[4] = '{2'b10,  4, 80'h1, 4'd13};
    tbl[5] = '{2'b11,  8, 80'hFFFF_0000_FFFF_0000_FFFF, 4'd13};
    tbl[6] = '{2'b00,  4, 80'h1357_9BDF_2468_ACE0_0F1E, 4'd13};
    tbl[7] = '{2'b01,  4, 80'h1, 4'd15};

    quadro = 80'h1;
    repeat (3) @(negedge clk);
    check("rst_col",  {25'd0, acender_coluna}, 32'h7F);
    check("rst_lin",  {27'd0, linhas}, 32'h0);
    check("rst_ini",  {31'd0, inicio_quadro}, 32'h0);
    check("rst_desl", {28'd0, deslocamento}, 32'h0);
    rst_n = 1'b1;

    @(negedge clk);
    check("first_ini",   {31'd0, inicio_quadro}, 32'd1);
    check("first_blank", {25'd0, acender_coluna}, 32'h7F);
    @(negedge clk);
    check("blank2_col", {25'd0, acender_coluna}, 32'h7F);
    check("blank2_ini", {31'd0, inicio_quadro}, 32'd0);
    @(negedge clk);
    check("col0_en",  {25'd0, acender_coluna}, 32'h3F);
    check("col0_lin", {27'd0, linhas}, 32'h01);
    repeat (5) @(negedge clk);
    check("col0_last", {25'd0, acender_coluna}, 32'h3F);
    @(negedge clk);
    check("slot1_blank", {25'd0, acender_coluna}, 32'h7F);
    repeat (2) @(negedge clk);
    check("col1_en",  {25'd0, acender_coluna}, 32'h5F);
    check("col1_lin", {27'd0, linhas}, 32'h00);

    wait_frame_start(n);
    wait_frame_start(n);
    check("frame_period", n, FRAME);

    for (int i = 0; i < 8; i++) begin
      {ch1, ch0} = tbl[i].ch;
      quadro = tbl[i].quadro;
      repeat (tbl[i].frames * FRAME) @(negedge clk);
      check("tbl_align", {31'd0, inicio_quadro}, 32'd1);
      check("tbl_desl",  {28'd0, deslocamento}, {28'd0, tbl[i].exp_desl});
    end

    // Mode change 01 -> 10 twenty cycles into a frame.
    quadro = 80'h1;
    d0 = deslocamento;
    check("mid_d0", {28'd0, d0}, 32'd15);
    repeat (20) @(negedge clk);
    {ch1, ch0} = 2'b10;
    wait_frame_start(n);
    wait_frame_start(n);
    check("mid_change_desl", {28'd0, deslocamento}, 32'd14);

    // Blink, then leave blink while hidden.
    {ch1, ch0} = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge clk);
      if (acender_coluna == 7'h7F) begin
        found = 1'b1;
        break;
      end
      wait_frame_start(n);
    end
    check("blink_hidden", {31'd0, found}, 32'd1);
    {ch1, ch0} = 2'b00;
    wait_frame_start(n);
    repeat (3) @(negedge clk);
    check("unblink_col0", {25'd0, acender_coluna}, 32'h3F);

    // Async reset during DRIVE of column 3 with offset 5.
    {ch1, ch0} = 2'b01;
    for (int i = 0; i < 40; i++) begin
      wait_frame_start(n);
      if (deslocamento == 4'd5) break;
    end
    check("reach_desl5", {28'd0, deslocamento}, 32'd5);
    {ch1, ch0} = 2'b00;
    wait_frame_start(n);
    repeat (28) @(negedge clk);
    check("pre_rst_col3", {25'd0, acender_coluna}, 32'h77);
    check("pre_rst_desl", {28'd0, deslocamento}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_col",  {25'd0, acender_coluna}, 32'h7F);
    check("async_lin",  {27'd0, linhas}, 32'h0);
    check("async_ini",  {31'd0, inicio_quadro}, 32'h0);
    check("async_desl", {28'd0, deslocamento}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_ini",  {31'd0, inicio_quadro}, 32'd1);
    check("restart_desl", {28'd0, deslocamento}, 32'd0);
    repeat (2) @(negedge clk);
    check("restart_col0", {25'd0, acender_coluna}, 32'h3F);

    repeat (2 * FRAME) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_varredura.md
Name: controlador_varredura

Overview:
- Scan and scroll controller for the 5x7 LED matrix. It replaces the free-running column register and slow-clock scroll registers with a single-clock scheduler.
- Time-multiplexes the 7 columns, inserts an anti-ghosting blank before each column and drives the 5 row lines with the pixels of the active column.
- Applies the ch1/ch0 display mode (static, scroll left, scroll right, blink) to a 5x16 frame supplied on a packed bus.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot (blank + drive); must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all columns off; must satisfy 1 <= BLANK_CYCLES < SCAN_DIV.
- SCROLL_FRAMES, 20: complete frames (7 slots each) per scroll step or blink toggle; must be >= 1.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst_n  in  1  asynchronous, active-low reset.
- ch1  in  1  mode select MSB (asynchronous switch).
- ch0  in  1  mode select LSB (asynchronous switch).
- quadro  in  80  frame data; row r = quadro[r*16 +: 16], r=0..4.
- acender_coluna  out  7  column enables, active low, one-hot-low or all-high.
- linhas  out  5  row data for the active column; bit r = row r, 1 = LED on.
- inicio_quadro  out  1  one-cycle pulse at the start of column 0's slot.
- deslocamento  out  4  current scroll offset, 0..15.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - acender_coluna = 7'h7F, linhas = 0, inicio_quadro = 0, deslocamento = 0.
  - Column index 0, slot counter 0, state BLANK.
  - Visible flag = 1, frame counter 0, latched mode = 00.
- Release: the first BLANK cycle is the first rising edge after rst_n goes high. Reset asserted mid-slot aborts immediately; there is no partial-frame resume.
- Mode inputs: ch1/ch0 pass through a 2-flop synchronizer. The synchronized value is latched as the active mode only on the cycle inicio_quadro is asserted. A mid-frame change takes effect at the next frame start.
- Slot FSM, two states, counter 0..SCAN_DIV-1:
  - BLANK:
    - acender_coluna = 7'h7F, linhas = 0.
    - Lasts BLANK_CYCLES cycles, then goes to DRIVE.
    - On the BLANK->DRIVE edge, linhas is registered from quadro. It is then held for the whole DRIVE phase; quadro changes mid-drive are not shown until the next slot.
  - DRIVE:
    - Column c is active: acender_coluna[6-c] = 0, all other bits = 1.
    - Lasts SCAN_DIV - BLANK_CYCLES cycles, then goes to BLANK with c = (c+1) mod 7.
- Column 0 maps to acender_coluna[6], matching the 0111111 start pattern.
- Pixel rule: linhas[r] = quadro[r*16 + ((deslocamento + c) mod 16)]; the 4-bit add wraps naturally.
- inicio_quadro is high for exactly the first BLANK cycle of column 0. One frame = 7*SCAN_DIV cycles.
- Frame counter: increments at each inicio_quadro. When it reaches SCROLL_FRAMES it wraps to 0 and produces a step event. The step applies at that same inicio_quadro, under the newly latched mode:
  - 00 static: offset held, visible = 1.
  - 01 scroll left: deslocamento +1 mod 16 (15 -> 0).
  - 10 scroll right: deslocamento -1 mod 16 (0 -> 15).
  - 11 blink: visible toggles, offset held.
- visible = 0 forces acender_coluna = 7'h7F for the whole frame. Slot timing, inicio_quadro and linhas sampling continue unchanged.
- Leaving blink sets visible = 1 at the latching inicio_quadro.
- Mode changes never reset deslocamento or the frame counter. Only rst_n clears them.
- All outputs are registered with no combinational path from inputs to outputs.
- Invariant: at most one acender_coluna bit is low in any cycle, and every column change is separated by at least BLANK_CYCLES all-high cycles.

Test Plan (SCAN_DIV=8, BLANK_CYCLES=2, SCROLL_FRAMES=2):
- Reset and first slot:
  - Stimulus: rst_n low, quadro row0 = 16'h0001, others 0, then release.
  - Response: 2 cycles of 7F/00, then acender_coluna = 7'h3F and linhas = 5'b00001 for 6 cycles.
  - Next slot: 7'h5F with linhas = 0.
  - inicio_quadro pulses every 56 cycles.
- Static mode:
  - Stimulus: ch = 00 held for 10 frames.
  - Response: deslocamento stays 0, and the column sequence 3F,5F,6F,77,7B,7D,7E repeats with blanks between.
- Scroll left wrap:
  - Stimulus: ch = 01.
  - Response: deslocamento increments every 2 frames, 15 -> 0 after 32 frames.
  - With row0 = 16'h0001, column 0 is lit only when deslocamento = 0; column c is lit when deslocamento = 16-c.
- Scroll right and mid-frame mode change:
  - Stimulus: ch switches 01 -> 10 at cycle 20 of a frame.
  - Response: no effect until the next inicio_quadro; afterwards deslocamento decrements, 0 -> 15.
- Blink:
  - Stimulus: ch = 11.
  - Response: acender_coluna stays 7'h7F for 2 frames, then scans normally for 2 frames.
  - inicio_quadro keeps pulsing throughout.
  - Switching to 00 while hidden restores display at the next frame.
- Async reset mid-drive:
  - Stimulus: rst_n asserted between clk edges during DRIVE of column 3 with deslocamento = 5.
  - Response: outputs go to 7'h7F/0/0 immediately, without waiting for clk.
  - After release, scanning restarts at column 0 with deslocamento = 0.
